// File: rtl/mux_scan_pkg.sv
// Shared constants, state encoding and channel-search helpers for the
// mux scan controller.
//   N_CH    : number of mux channels
//   SEL_W   : select width, clog2(N_CH)
//   DWELL_W : width of the per-channel settle count
package mux_scan_pkg;

   localparam int unsigned N_CH    = 4;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned DWELL_W = 4;

   typedef logic [N_CH-1:0]    mask_t;
   typedef logic [SEL_W-1:0]   sel_t;
   typedef logic [DWELL_W-1:0] dwell_t;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StDone
   } state_e;

   typedef struct packed {
      logic found;
      sel_t idx;
   } next_ch_t;

   // Lowest enabled index strictly above cur. Scanning downward and
   // overwriting leaves the lowest qualifying index in the result.
   function automatic next_ch_t next_above(input mask_t en, input sel_t cur);
      next_ch_t r;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (i > int'(cur) && en[i]) begin
            r.found = 1'b1;
            r.idx   = sel_t'(i);
         end
      end
      return r;
   endfunction

   // Lowest enabled index overall; found=0 for an empty mask.
   function automatic next_ch_t lowest_en(input mask_t en);
      next_ch_t r;
      r = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (en[i]) begin
            r.found = 1'b1;
            r.idx   = sel_t'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle of the scan controller's control, mux and frame-handshake signals.
//   start/ch_en/dwell : scan request and its configuration
//   sel/mux_out       : connection to the 4:1 mux
//   frame/frame_valid/frame_ready : captured frame and its handshake
//   busy              : scan in progress or frame pending
// slave is the controller's view; master is the surrounding system's view.
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;

   logic   start;
   mask_t  ch_en;
   dwell_t dwell;
   sel_t   sel;
   logic   mux_out;
   mask_t  frame;
   logic   frame_valid;
   logic   frame_ready;
   logic   busy;

   modport slave (
      input  start, ch_en, dwell, mux_out, frame_ready,
      output sel, frame, frame_valid, busy
   );

   modport master (
      output start, ch_en, dwell, mux_out, frame_ready,
      input  sel, frame, frame_valid, busy
   );

endinterface

// File: rtl/mux_scan_next.sv
// Combinational next-channel search for the scan sequence.
//   en_i       : latched channel enable mask
//   sel_i      : currently selected channel
//   sel_nxt_o  : lowest enabled channel above sel_i (valid when has_next_o)
//   has_next_o : a higher-index enabled channel exists
module mux_scan_next
   import mux_scan_pkg::*;
(
   input  mask_t en_i,
   input  sel_t  sel_i,
   output sel_t  sel_nxt_o,
   output logic  has_next_o
);

   next_ch_t nxt;

   always_comb begin
      nxt        = next_above(en_i, sel_i);
      sel_nxt_o  = nxt.idx;
      has_next_o = nxt.found;
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scanned channel sampler in front of a 4:1 single-bit mux. Steps sel through
// the enabled channels in ascending order, holds each for dwell+1 cycles,
// samples mux_out on the last cycle of each channel, and presents the frame
// over a valid/ready handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : control, mux and frame handshake signals (slave view)
// All outputs come straight from registers or decoded state.
module mux_scan_ctrl
   import mux_scan_pkg::*;
(
   input logic            clk,
   input logic            rst_n,
   mux_scan_ctrl_if.slave bus
);

   state_e   state_q, state_d;
   sel_t     sel_q, sel_d;
   dwell_t   cnt_q, cnt_d;
   mask_t    en_q, en_d;
   dwell_t   dwell_q, dwell_d;
   mask_t    frame_q, frame_d;

   sel_t     sel_nxt;
   logic     has_next;
   next_ch_t first_ch;

   mux_scan_next u_next (
      .en_i       (en_q),
      .sel_i      (sel_q),
      .sel_nxt_o  (sel_nxt),
      .has_next_o (has_next)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      dwell_d  = dwell_q;
      frame_d  = frame_q;
      first_ch = lowest_en(bus.ch_en);

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               en_d    = bus.ch_en;
               dwell_d = bus.dwell;
               frame_d = '0;
               if (!first_ch.found) begin
                  state_d = StDone;
               end else begin
                  sel_d   = first_ch.idx;
                  cnt_d   = bus.dwell;
                  state_d = StSettle;
               end
            end
         end
         StSettle: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - dwell_t'(1);
            end else begin
               frame_d[sel_q] = bus.mux_out;
               if (has_next) begin
                  sel_d = sel_nxt;
                  cnt_d = dwell_q;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            // start is deliberately not looked at here; a new scan needs IDLE.
            if (bus.frame_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sel_q   <= '0;
         cnt_q   <= '0;
         en_q    <= '0;
         dwell_q <= '0;
         frame_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         dwell_q <= dwell_d;
         frame_q <= frame_d;
      end
   end

   assign bus.sel         = sel_q;
   assign bus.frame       = frame_q;
   assign bus.frame_valid = (state_q == StDone);
   assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;
   import mux_scan_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] mux_data = 4'b0000;
   int         checks = 0;
   int         errors = 0;

   mux_scan_ctrl_if bus ();

   // The 4:1 single-bit mux being scanned.
   assign bus.mux_out = mux_data[bus.sel];

   mux_scan_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One complete scan. Expectations come from the scan rules: each enabled
   // channel, ascending, appears dwell+1 times; frame = data & enable mask;
   // valid appears k*(dwell+1)+1 edges counting the accepting edge.
   task automatic run_scan(input logic [3:0] en, input logic [3:0] d, input logic [3:0] data,
                           input int rd, input bit noise, input bit change_data);
      logic [3:0] exp_frame;
      int         exp_sel[$];
      int         len;
      exp_frame = data & en;
      for (int c = 0; c < 4; c++) begin
         if (en[c]) begin
            for (int r = 0; r <= int'(d); r++) exp_sel.push_back(c);
         end
      end
      len = exp_sel.size();

      mux_data        = data;
      bus.ch_en       = en;
      bus.dwell       = d;
      bus.frame_ready = (rd == 0);
      bus.start       = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;

      for (int j = 0; j < len; j++) begin
         check("settle_busy", 32'(bus.busy), 32'd1);
         check("settle_valid", 32'(bus.frame_valid), 32'd0);
         check("settle_sel", 32'(bus.sel), 32'(exp_sel[j]));
         if (noise) begin
            bus.ch_en = 4'($urandom);
            bus.dwell = 4'($urandom);
            bus.start = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;

      check("done_valid", 32'(bus.frame_valid), 32'd1);
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_frame", 32'(bus.frame), 32'(exp_frame));
      if (len > 0) check("done_sel", 32'(bus.sel), 32'(exp_sel[len-1]));

      for (int j = 0; j < rd; j++) begin
         check("hold_valid", 32'(bus.frame_valid), 32'd1);
         check("hold_frame", 32'(bus.frame), 32'(exp_frame));
         if (len > 0) check("hold_sel", 32'(bus.sel), 32'(exp_sel[len-1]));
         if (change_data) mux_data = 4'($urandom);
         bus.start = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end

      // Handshake, possibly with start high at the same time.
      bus.frame_ready = 1'b1;
      bus.start       = 1'($urandom_range(0, 1));
      if (rd > 0) begin
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
      end
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_valid", 32'(bus.frame_valid), 32'd0);
      check("idle_frame", 32'(bus.frame), 32'(exp_frame));
      bus.start       = 1'b0;
      bus.frame_ready = 1'b0;
      @(posedge clk); #1;
      check("idle_stay", 32'(bus.busy), 32'd0);
      check("idle_frame_hold", 32'(bus.frame), 32'(exp_frame));
   endtask

   initial begin
      bus.start       = 1'b0;
      bus.ch_en       = '0;
      bus.dwell       = '0;
      bus.frame_ready = 1'b0;
      #12;
      check("rst_sel", 32'(bus.sel), 32'd0);
      check("rst_frame", 32'(bus.frame), 32'd0);
      check("rst_valid", 32'(bus.frame_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases.
      run_scan(4'b1111, 4'd0,  4'b1010, 0, 1'b0, 1'b0);
      run_scan(4'b0101, 4'd3,  4'b1111, 2, 1'b0, 1'b0);
      run_scan(4'b0000, 4'd2,  4'b1111, 4, 1'b0, 1'b0);
      run_scan(4'b1111, 4'd1,  4'b1010, 10, 1'b0, 1'b1);
      run_scan(4'b1011, 4'd2,  4'b0110, 1, 1'b1, 1'b0);
      run_scan(4'b1000, 4'd15, 4'b1000, 1, 1'b0, 1'b0);

      // Reset in the middle of SETTLE clears outputs without a clock.
      mux_data  = 4'b1111;
      bus.ch_en = 4'b1111;
      bus.dwell = 4'd3;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("mid_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_sel", 32'(bus.sel), 32'd0);
      check("arst_frame", 32'(bus.frame), 32'd0);
      check("arst_valid", 32'(bus.frame_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_scan(4'b0110, 4'd1, 4'b0100, 0, 1'b0, 1'b0);

      // Randomized scans.
      for (int n = 0; n < 25; n++) begin
         logic [3:0] en, d, data;
         en   = 4'($urandom);
         d    = (n % 6 == 5) ? 4'd15 : 4'($urandom_range(0, 4));
         data = 4'($urandom);
         run_scan(en, d, data, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
